// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode map, flag bit positions and saturating-add helper shared by alu_pipe
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;

    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_N = 0;

    localparam int SAT_MAX_W = 64;

    // Operands arrive sign-extended to SAT_MAX_W; w selects the signed range to clamp into.
    function automatic logic signed [SAT_MAX_W-1:0] sat_add(
        input logic signed [SAT_MAX_W-1:0] a,
        input logic signed [SAT_MAX_W-1:0] b,
        input int unsigned                 w
    );
        logic signed [SAT_MAX_W:0] sum;
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        sum = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
        hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo  = -(65'sd1 <<< (w - 1));
        if (sum > hi)
            sat_add = hi[SAT_MAX_W-1:0];
        else if (sum < lo)
            sat_add = lo[SAT_MAX_W-1:0];
        else
            sat_add = sum[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// rtl/alu_pipe_core.sv - combinational ALU between the two pipeline registers
// ALU_SAT_EN: ADD/SUB clamp on signed overflow instead of wrapping.
module alu_pipe_core
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4,
    parameter int SHW    = $clog2(WIDTH)
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flag_val,
    output logic [2:0]       flag_mask
);

    localparam int NLANES = WIDTH / LANE_W;
    localparam int NBYTES = 2 * WIDTH / 8;

    logic                    sub;
    logic [WIDTH-1:0]        b_eff;
    logic [WIDTH-1:0]        sum;
    logic                    ovf;
    logic [SHW-1:0]          amt;
    logic [SHW:0]            ramt;
    logic [2*WIDTH-1:0]      ab;
    logic signed [WIDTH-1:0] red_acc;
    logic [WIDTH-1:0]        lanes;
    logic [LANE_W-1:0]       la;
    logic [LANE_W-1:0]       lb;

    always_comb begin
        sub   = (op == OP_SUB);
        b_eff = sub ? ~b : b;
        sum   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
        ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

        amt  = b[SHW-1:0];
        ramt = (SHW+1)'(WIDTH) - {1'b0, amt};

        ab      = {a, b};
        red_acc = '0;
        for (int i = 0; i < NBYTES; i++)
            red_acc = red_acc + WIDTH'($signed(ab[8*i +: 8]));

        lanes = '0;
        la    = '0;
        lb    = '0;
        for (int l = 0; l < NLANES; l++) begin
            la = a[l*LANE_W +: LANE_W];
            lb = b[l*LANE_W +: LANE_W];
            lanes[l*LANE_W +: LANE_W] = LANE_W'(sat_add(SAT_MAX_W'($signed(la)),
                                                        SAT_MAX_W'($signed(lb)), LANE_W));
        end

        result    = '1;
        flag_mask = '0;
        case (op)
            OP_ADD, OP_SUB: begin
`ifdef ALU_SAT_EN
                // On overflow both effective operands share A's sign, so A picks the rail.
                result = ovf ? {a[WIDTH-1], {(WIDTH-1){~a[WIDTH-1]}}} : sum;
`else
                result = sum;
`endif
                flag_mask = 3'b111;
            end
            OP_XOR: begin
                result           = a ^ b;
                flag_mask[FLG_Z] = 1'b1;
            end
            OP_RED:    result = red_acc;
            OP_SLL: begin
                result           = a << amt;
                flag_mask[FLG_Z] = 1'b1;
            end
            OP_SRA: begin
                result           = $signed(a) >>> amt;
                flag_mask[FLG_Z] = 1'b1;
            end
            OP_ROR: begin
                result           = (a >> amt) | (a << ramt);
                flag_mask[FLG_Z] = 1'b1;
            end
            OP_PADDSB: result = lanes;
            OP_LW, OP_SW: result = a + b;
            default:   result = '1;
        endcase

        flag_val        = '0;
        flag_val[FLG_Z] = (result == '0);
        flag_val[FLG_V] = ovf;
        flag_val[FLG_N] = result[WIDTH-1];
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline with Z/V/N flag register and flush
// ALU_SAT_EN (in alu_pipe_core) selects saturating ADD/SUB.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4,
    parameter int SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_op,
    output logic [2:0]       flags
);

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;
    logic [2:0]       s2_flag_val;
    logic [2:0]       s2_flag_mask;
    logic [WIDTH-1:0] core_result;
    logic [2:0]       core_flag_val;
    logic [2:0]       core_flag_mask;
    logic             s1_adv;
    logic             s2_adv;
    logic             out_fire;

    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;
    assign out_fire  = s2_valid & out_ready;

    alu_pipe_core #(
        .WIDTH  (WIDTH),
        .LANE_W (LANE_W),
        .SHW    (SHW)
    ) u_core (
        .op        (s1_op),
        .a         (s1_a),
        .b         (s1_b),
        .result    (core_result),
        .flag_val  (core_flag_val),
        .flag_mask (core_flag_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_op        <= '0;
            s1_a         <= '0;
            s1_b         <= '0;
            s2_valid     <= 1'b0;
            out_result   <= '0;
            out_op       <= '0;
            s2_flag_val  <= '0;
            s2_flag_mask <= '0;
            flags        <= '0;
        end else begin
            // The op leaving this cycle retires even if a flush is also requested.
            if (out_fire)
                flags <= (flags & ~s2_flag_mask) | (s2_flag_val & s2_flag_mask);
            if (flush) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (s1_adv) begin
                    s1_valid <= in_valid;
                    if (in_valid) begin
                        s1_op <= in_op;
                        s1_a  <= in_a;
                        s1_b  <= in_b;
                    end
                end
                if (s2_adv) begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        out_result   <= core_result;
                        out_op       <= s1_op;
                        s2_flag_val  <= core_flag_val;
                        s2_flag_mask <= core_flag_mask;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe (WIDTH=16), valid with or without ALU_SAT_EN
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 16;
`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   in_op, out_op;
    logic [W-1:0] in_a, in_b, out_result;
    logic [2:0]   flags;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] res;
        logic [2:0]   wm;
        logic [2:0]   wv;
    } exp_t;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
    } vec_t;

    exp_t         sb_q[$];
    logic [2:0]   m_flags    = 3'b000;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_res;
    logic [3:0]   prev_op;
    vec_t         vecs[14];

    alu_pipe #(.WIDTH(W), .LANE_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode definitions.
    function automatic exp_t ref_compute(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa, sb, s, amt, acc, ls;
        logic ovf;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        amt = int'(b[3:0]);
        ovf = 1'b0;
        e.op  = op;
        e.res = '1;
        e.wm  = 3'b000;
        case (op)
            OP_ADD, OP_SUB: begin
                s   = (op == OP_SUB) ? sa - sb : sa + sb;
                ovf = (s > 32767) || (s < -32768);
                if (SAT && ovf) e.res = (s > 0) ? 16'h7FFF : 16'h8000;
                else            e.res = 16'(s);
                e.wm = 3'b111;
            end
            OP_XOR: begin e.res = a ^ b; e.wm = 3'b100; end
            OP_RED: begin
                acc = 0;
                for (int i = 0; i < 2; i++)
                    acc = acc + int'($signed(a[8*i +: 8])) + int'($signed(b[8*i +: 8]));
                e.res = 16'(acc);
            end
            OP_SLL: begin e.res = 16'(int'(a) << amt); e.wm = 3'b100; end
            OP_SRA: begin e.res = 16'(sa >>> amt);     e.wm = 3'b100; end
            OP_ROR: begin
                e.res = a;
                for (int i = 0; i < amt; i++) e.res = {e.res[0], e.res[W-1:1]};
                e.wm = 3'b100;
            end
            OP_PADDSB: begin
                for (int l = 0; l < 4; l++) begin
                    ls = int'($signed(a[4*l +: 4])) + int'($signed(b[4*l +: 4]));
                    if (ls > 7)  ls = 7;
                    if (ls < -8) ls = -8;
                    e.res[4*l +: 4] = 4'(ls);
                end
            end
            OP_LW, OP_SW: e.res = a + b;
            default: e.res = '1;
        endcase
        e.wv = {e.res == 16'h0000, ovf, e.res[W-1]};
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Scoreboard monitor: in-order queue of accepted ops, flags model, stall stability.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                m_flags    = 3'b000;
                prev_stall = 1'b0;
            end else begin
                check("flags_model", flags, m_flags);
                if (prev_stall) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_result", out_result, prev_res);
                    check("stall_op", out_op, prev_op);
                end
                if (out_valid && out_ready) begin
                    check("out_has_expect", 32'(sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("sb_result", out_result, e.res);
                        check("sb_op", out_op, e.op);
                        m_flags = (m_flags & ~e.wm) | (e.wv & e.wm);
                    end
                end
                prev_stall = out_valid && !out_ready && !flush;
                prev_res   = out_result;
                prev_op    = out_op;
                if (flush)
                    sb_q.delete();
                else if (in_valid && in_ready)
                    sb_q.push_back(ref_compute(in_op, in_a, in_b));
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] res);
        int lat;
        send(op, a, b);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check({name, "_latency"}, lat, 2);
        check({name, "_result"}, out_result, res);
        check({name, "_op"}, out_op, op);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;

        vecs[0]  = '{OP_ADD,    16'h7000, 16'h1000, SAT ? 16'h7FFF : 16'h8000};
        vecs[1]  = '{OP_SUB,    16'h0005, 16'h0005, 16'h0000};
        vecs[2]  = '{OP_XOR,    16'h00FF, 16'h0F00, 16'h0FFF};
        vecs[3]  = '{OP_PADDSB, 16'h7878, 16'h1111, 16'h7979};
        vecs[4]  = '{OP_ROR,    16'h8001, 16'h0004, 16'h1800};
        vecs[5]  = '{OP_SRA,    16'h8000, 16'h000F, 16'hFFFF};
        vecs[6]  = '{OP_RED,    16'h7F01, 16'h80FF, 16'hFFFF};
        vecs[7]  = '{OP_SLL,    16'h1234, 16'h0010, 16'h1234};
        vecs[8]  = '{OP_LW,     16'hFFFF, 16'h0002, 16'h0001};
        vecs[9]  = '{OP_SW,     16'h7FFF, 16'h0001, 16'h8000};
        vecs[10] = '{4'hA,      16'h1234, 16'h5678, 16'hFFFF};
        vecs[11] = '{OP_SUB,    16'h8000, 16'h0001, SAT ? 16'h8000 : 16'h7FFF};
        vecs[12] = '{OP_PADDSB, 16'h8888, 16'h8888, 16'h8888};
        vecs[13] = '{OP_SLL,    16'h0001, 16'h000F, 16'h8000};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_op", out_op, 0);
        check("rst_flags", flags, 0);
        check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res);

        run_op("t1_add", OP_ADD, 16'h7000, 16'h1000, SAT ? 16'h7FFF : 16'h8000);
        check("t1_flags", flags, SAT ? 3'b010 : 3'b011);
        run_op("t2_sub", OP_SUB, 16'h0005, 16'h0005, 16'h0000);
        check("t2_sub_flags", flags, 3'b100);
        run_op("t2_xor", OP_XOR, 16'h00FF, 16'h0F00, 16'h0FFF);
        check("t2_xor_flags", flags, 3'b000);
        run_op("t2_add_v", OP_ADD, 16'h7000, 16'h1000, SAT ? 16'h7FFF : 16'h8000);
        run_op("t2_xor_hold", OP_XOR, 16'h00FF, 16'h0F00, 16'h0FFF);
        check("t2_xor_hold_flags", flags, SAT ? 3'b010 : 3'b011);
        run_op("t2_red_hold", OP_RED, 16'h7F01, 16'h80FF, 16'hFFFF);
        check("t2_red_hold_flags", flags, SAT ? 3'b010 : 3'b011);

        // Backpressure: three back-to-back ops, consumer stalled for four cycles.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_op = OP_ADD; in_a = 16'd1; in_b = 16'd2;
        @(negedge clk); check("bp_rdy0", in_ready, 1);
        @(posedge clk); #1; in_a = 16'd3; in_b = 16'd4;
        @(negedge clk); check("bp_rdy1", in_ready, 1);
        @(posedge clk); #1; in_op = OP_XOR; in_a = 16'hF0F0; in_b = 16'h0FF0;
        @(negedge clk); check("bp_rdy2", in_ready, 0); check("bp_res2", out_result, 16'd3);
        @(posedge clk); #1;
        @(negedge clk); check("bp_rdy3", in_ready, 0); check("bp_val3", out_valid, 1);
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk); check("bp_rdy4", in_ready, 1); check("bp_res4", out_result, 16'd3);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); check("bp_val5", out_valid, 1); check("bp_res5", out_result, 16'd7);
        @(posedge clk); #1;
        @(negedge clk); check("bp_val6", out_valid, 1); check("bp_res6", out_result, 16'hFF00);
        @(posedge clk); #1;
        @(negedge clk); check("bp_val7", out_valid, 0);
        check("bp_flags", flags, 3'b000);

        // Flush with both stages full and the consumer stalled.
        @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b1; in_op = OP_SUB; in_a = 16'd5; in_b = 16'd5;
        @(posedge clk); #1; in_op = OP_ADD; in_a = 16'h7000; in_b = 16'h1000;
        @(posedge clk); #1; flush = 1'b1; in_op = OP_SUB;
        @(negedge clk); check("fl_full", in_ready, 0);
        @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fl_out_valid", out_valid, 0);
        check("fl_flags", flags, 3'b000);
        check("fl_in_ready", in_ready, 1);

        // Input offered in the flush cycle is dropped.
        @(posedge clk); #1; out_ready = 1'b1; in_valid = 1'b1; in_op = OP_SUB; in_a = 16'd5; in_b = 16'd5; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("fl_drop_valid%0d", i), out_valid, 0);
        end
        check("fl_drop_flags", flags, 3'b000);

        // An op transferring out in the flush cycle still retires and writes flags.
        send(OP_SUB, 16'd5, 16'd5);
        @(posedge clk); #1; flush = 1'b1;
        @(negedge clk); check("fl_retire_valid", out_valid, 1);
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk); check("fl_retire_flags", flags, 3'b100);

        // Reset with a SUB in flight.
        send(OP_SUB, 16'd9, 16'd3);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("rs_out_valid", out_valid, 0);
        check("rs_flags", flags, 3'b000);
        check("rs_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rs_no_stale%0d", i), out_valid, 0);
        end

        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 4'($urandom_range(0, 15));
            in_a      = pick();
            in_b      = pick();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("drain_empty", sb_q.size(), 0);
        check("drain_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
